// File: rtl/periph_bus_pkg.sv
// Shared types and constants for the peripheral bus arbiter.
package periph_bus_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACCESS    = 2'd1,
        LOCK_WAIT = 2'd2
    } state_t;

    // Master indices.
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // Peripheral register word addresses.
    localparam logic [ADDR_W-1:0] ADDR_TH     = 32'h4000_0000;
    localparam logic [ADDR_W-1:0] ADDR_TL     = 32'h4000_0004;
    localparam logic [ADDR_W-1:0] ADDR_TCON   = 32'h4000_0008;
    localparam logic [ADDR_W-1:0] ADDR_LED    = 32'h4000_000C;
    localparam logic [ADDR_W-1:0] ADDR_SWITCH = 32'h4000_0010;
    localparam logic [ADDR_W-1:0] ADDR_DIGI   = 32'h4000_0014;

    // One master's bus command.
    typedef struct packed {
        logic              rd;
        logic              wr;
        logic              lock;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_cmd_t;

    // True when a command must be answered with an error instead of a bus cycle.
    function automatic logic cmd_bad(input bus_cmd_t cmd,
                                     input logic [ADDR_W-1:0] base,
                                     input logic [ADDR_W-1:0] last);
        return (cmd.addr < base) || (cmd.addr > last) ||
               (cmd.addr[1:0] != 2'b00) || (cmd.rd == cmd.wr);
    endfunction

endpackage

// File: rtl/periph_bus_arbiter_rr_arb2.sv
// Two-way combinational round-robin picker.
module rr_arb2
    import periph_bus_pkg::*;
(
    input  logic [1:0] eligible,
    input  logic       last_served,
    input  logic       exclude_valid,
    input  logic       exclude_idx,
    output logic       grant_valid,
    output logic       grant_idx
);

    logic [1:0] w_mask;
    logic [1:0] w_cand;

    // Drop the excluded master, then break ties against the last one served.
    always_comb begin
        w_mask = 2'b00;
        if (exclude_valid) begin
            w_mask[exclude_idx] = 1'b1;
        end
        w_cand      = eligible & ~w_mask;
        grant_valid = |w_cand;
        grant_idx   = M0;
        if (&w_cand) begin
            grant_idx = ~last_served;
        end else if (w_cand[M1]) begin
            grant_idx = M1;
        end
    end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Peripheral register bus arbiter: CPU (M0) and DMA/UART (M1) share one
// registered access per cycle, with locked RMW sequences and a lock timeout.
module periph_bus_arbiter
    import periph_bus_pkg::*;
#(
    parameter int unsigned       LOCK_TIMEOUT = 16,
    parameter logic [ADDR_W-1:0] ADDR_BASE    = 32'h4000_0000,
    parameter logic [ADDR_W-1:0] ADDR_LAST    = 32'h4000_0014
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_rd,
    input  logic              m0_wr,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_rd,
    input  logic              m1_wr,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              p_rd,
    output logic              p_wr,
    output logic [ADDR_W-1:0] p_addr,
    output logic [DATA_W-1:0] p_wdata,
    input  logic [DATA_W-1:0] p_rdata,
    output logic              lock_err
);

    localparam int unsigned TMR_W = $clog2(LOCK_TIMEOUT + 1);

    state_t            r_state;
    logic              r_owner;
    logic              r_last;
    logic              r_lock;
    logic              r_err;
    logic [TMR_W-1:0]  r_timer;
    logic              r_p_rd;
    logic              r_p_wr;
    logic [ADDR_W-1:0] r_p_addr;
    logic [DATA_W-1:0] r_p_wdata;
    logic              r_m0_ack;
    logic              r_m0_err;
    logic [DATA_W-1:0] r_m0_rdata;
    logic              r_m1_ack;
    logic              r_m1_err;
    logic [DATA_W-1:0] r_m1_rdata;
    logic              r_lock_err;

    bus_cmd_t          w_cmd_m0;
    bus_cmd_t          w_cmd_m1;
    bus_cmd_t          w_cmd;
    logic [1:0]        w_elig;
    logic              w_grant_valid;
    logic              w_grant_idx;
    logic              w_sel_idx;
    logic              w_load;
    logic              w_bad;

    assign w_cmd_m0 = {m0_rd, m0_wr, m0_lock, m0_addr, m0_wdata};
    assign w_cmd_m1 = {m1_rd, m1_wr, m1_lock, m1_addr, m1_wdata};

    // A master's command in its own ack cycle is stale.
    assign w_elig = {m1_req & ~r_m1_ack, m0_req & ~r_m0_ack};

    rr_arb2 u_arb (
        .eligible      (w_elig),
        .last_served   (r_last),
        .exclude_valid (r_state == ACCESS),
        .exclude_idx   (r_owner),
        .grant_valid   (w_grant_valid),
        .grant_idx     (w_grant_idx)
    );

    // Decide whether a new command is loaded onto the bus at this edge, and whose.
    always_comb begin
        w_sel_idx = w_grant_idx;
        w_load    = 1'b0;
        case (r_state)
            IDLE:      w_load = w_grant_valid;
            ACCESS:    w_load = ~r_lock & w_grant_valid;
            LOCK_WAIT: begin
                w_sel_idx = r_owner;
                w_load    = w_elig[r_owner];
            end
            default:   w_load = 1'b0;
        endcase
        w_cmd = w_sel_idx ? w_cmd_m1 : w_cmd_m0;
        w_bad = cmd_bad(w_cmd, ADDR_BASE, ADDR_LAST);
    end

    // Arbiter FSM with registered bus strobes and master responses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_owner    <= M0;
            r_last     <= M1;
            r_lock     <= 1'b0;
            r_err      <= 1'b0;
            r_timer    <= '0;
            r_p_rd     <= 1'b0;
            r_p_wr     <= 1'b0;
            r_p_addr   <= '0;
            r_p_wdata  <= '0;
            r_m0_ack   <= 1'b0;
            r_m0_err   <= 1'b0;
            r_m0_rdata <= '0;
            r_m1_ack   <= 1'b0;
            r_m1_err   <= 1'b0;
            r_m1_rdata <= '0;
            r_lock_err <= 1'b0;
        end else begin
            r_m0_ack  <= 1'b0;
            r_m0_err  <= 1'b0;
            r_m1_ack  <= 1'b0;
            r_m1_err  <= 1'b0;
            r_p_rd    <= 1'b0;
            r_p_wr    <= 1'b0;
            r_p_addr  <= '0;
            r_p_wdata <= '0;
            case (r_state)
                IDLE: begin
                    if (w_load) begin
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_last <= r_owner;
                    if (r_owner == M1) begin
                        r_m1_ack   <= 1'b1;
                        r_m1_err   <= r_err;
                        r_m1_rdata <= r_p_rd ? p_rdata : '0;
                    end else begin
                        r_m0_ack   <= 1'b1;
                        r_m0_err   <= r_err;
                        r_m0_rdata <= r_p_rd ? p_rdata : '0;
                    end
                    if (r_lock) begin
                        r_state <= LOCK_WAIT;
                        r_timer <= '0;
                    end else if (w_load) begin
                        r_state <= ACCESS;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                LOCK_WAIT: begin
                    if (w_load) begin
                        r_state <= ACCESS;
                    end else if (r_timer + TMR_W'(1) == TMR_W'(LOCK_TIMEOUT)) begin
                        r_state    <= IDLE;
                        r_lock_err <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
            // Erroneous commands still take an ACCESS slot but never touch the bus.
            if (w_load) begin
                r_owner   <= w_sel_idx;
                r_err     <= w_bad;
                r_lock    <= w_cmd.lock & ~w_bad;
                r_p_rd    <= w_cmd.rd & ~w_bad;
                r_p_wr    <= w_cmd.wr & ~w_bad;
                r_p_addr  <= w_bad ? '0 : w_cmd.addr;
                r_p_wdata <= w_bad ? '0 : w_cmd.wdata;
            end
        end
    end

    assign m0_ack   = r_m0_ack;
    assign m0_err   = r_m0_err;
    assign m0_rdata = r_m0_rdata;
    assign m1_ack   = r_m1_ack;
    assign m1_err   = r_m1_err;
    assign m1_rdata = r_m1_rdata;
    assign p_rd     = r_p_rd;
    assign p_wr     = r_p_wr;
    assign p_addr   = r_p_addr;
    assign p_wdata  = r_p_wdata;
    assign lock_err = r_lock_err;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Testbench for periph_bus_arbiter: directed scenarios plus a randomized
// two-master phase checked against a transaction-level reference model.
module tb_periph_bus_arbiter;
    import periph_bus_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_rd, m0_wr, m0_lock;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m0_ack, m0_err;
    logic        m1_req, m1_rd, m1_wr, m1_lock;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        m1_ack, m1_err;
    logic        p_rd, p_wr, lock_err;
    logic [31:0] p_addr, p_wdata, p_rdata;

    // Peripheral register file stub with a backdoor write port.
    logic [31:0] pmem [8];
    logic        bd_we;
    logic [2:0]  bd_idx;
    logic [31:0] bd_data;

    int n_chk  = 0;
    int n_pass = 0;

    // Randomized-phase reference state.
    logic        rnd_busy      [2];
    int          rnd_wait      [2];
    logic        rnd_exp_err   [2];
    logic [31:0] rnd_exp_rdata [2];
    logic [31:0] ref_mem       [6];
    logic        c_ack, c_err, c_rd, c_wr;
    logic [31:0] c_rdata, c_addr, c_wdata;
    logic [2:0]  c_idx;
    int          r;
    logic [31:0] saved;

    always #5 clk = ~clk;

    periph_bus_arbiter #(.LOCK_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_rd(m0_rd), .m0_wr(m0_wr), .m0_lock(m0_lock),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_rd(m1_rd), .m1_wr(m1_wr), .m1_lock(m1_lock),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .p_rd(p_rd), .p_wr(p_wr), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_rdata(p_rdata), .lock_err(lock_err)
    );

    assign p_rdata = pmem[p_addr[4:2]];

    always @(posedge clk) begin
        if (bd_we) pmem[bd_idx] <= bd_data;
        else if (p_wr) pmem[p_addr[4:2]] <= p_wdata;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {25'd0, m0_ack, m0_err, m1_ack, m1_err, p_rd, p_wr, lock_err}, 32'd0);
        chk(tag, m0_rdata, 32'd0);
        chk(tag, m1_rdata, 32'd0);
        chk(tag, p_addr, 32'd0);
        chk(tag, p_wdata, 32'd0);
    endtask

    task automatic set_m0(input logic req, input logic rd, input logic wr, input logic lock,
                          input logic [31:0] addr, input logic [31:0] wdata);
        m0_req = req; m0_rd = rd; m0_wr = wr; m0_lock = lock; m0_addr = addr; m0_wdata = wdata;
    endtask

    task automatic set_m1(input logic req, input logic rd, input logic wr, input logic lock,
                          input logic [31:0] addr, input logic [31:0] wdata);
        m1_req = req; m1_rd = rd; m1_wr = wr; m1_lock = lock; m1_addr = addr; m1_wdata = wdata;
    endtask

    task automatic set_m(input int idx, input logic req, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (idx == 0) set_m0(req, rd, wr, 1'b0, addr, wdata);
        else          set_m1(req, rd, wr, 1'b0, addr, wdata);
    endtask

    task automatic backdoor(input logic [2:0] idx, input logic [31:0] data);
        bd_we = 1'b1; bd_idx = idx; bd_data = data;
        step();
        bd_we = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // M1 issues one command that must be rejected without a bus cycle.
    task automatic err_case(input string tag, input logic rd, input logic wr, input logic lock,
                            input logic [31:0] addr);
        set_m1(1'b1, rd, wr, lock, addr, 32'h0000_5A5A);
        step();
        chk1({tag, "_prd"}, p_rd, 1'b0);
        chk1({tag, "_pwr"}, p_wr, 1'b0);
        step();
        chk1({tag, "_ack"}, m1_ack, 1'b1);
        chk1({tag, "_err"}, m1_err, 1'b1);
        chk({tag, "_rdata"}, m1_rdata, 32'd0);
        set_m1(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step();
    endtask

    // Spec-level error rule for the randomized model.
    function automatic logic ref_err(input logic [31:0] a, input logic rd, input logic wr);
        return (a < 32'h4000_0000) || (a > 32'h4000_0014) || (a[1:0] != 2'b00) || (rd == wr);
    endfunction

    // Each master owns three registers so its results never depend on the other's order.
    function automatic logic [2:0] pick_idx(input int m, input int k);
        if (m == 0) return (k == 0) ? 3'd0 : (k == 1) ? 3'd3 : 3'd5;
        return (k == 0) ? 3'd1 : (k == 1) ? 3'd2 : 3'd4;
    endfunction

    initial begin
        reset = 1'b1;
        bd_we = 1'b0; bd_idx = 3'd0; bd_data = 32'd0;
        set_m0(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_m1(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 8; i++) backdoor(3'(i), 32'd0);
        chk_zero("reset_state");
        reset = 1'b0;

        backdoor(3'd4, 32'h0000_00A5);
        backdoor(3'd1, 32'h0000_0010);
        backdoor(3'd2, 32'h0000_0005);
        backdoor(3'd5, 32'h0000_0077);

        // Single read with latency check.
        set_m0(1'b1, 1'b1, 1'b0, 1'b0, ADDR_SWITCH, 32'd0);
        step();
        chk1("t1_prd", p_rd, 1'b1);
        chk("t1_paddr", p_addr, ADDR_SWITCH);
        chk1("t1_ack_early", m0_ack, 1'b0);
        step();
        chk1("t1_ack", m0_ack, 1'b1);
        chk("t1_rdata", m0_rdata, 32'h0000_00A5);
        chk1("t1_err", m0_err, 1'b0);
        chk1("t1_prd_one_cycle", p_rd, 1'b0);
        set_m0(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step();
        chk1("t1_ack_pulse", m0_ack, 1'b0);
        chk("t1_rdata_hold", m0_rdata, 32'h0000_00A5);

        // Simultaneous requests after reset: M0 first, M1 back-to-back.
        do_reset();
        set_m0(1'b1, 1'b0, 1'b1, 1'b0, ADDR_LED, 32'h0000_003C);
        set_m1(1'b1, 1'b1, 1'b0, 1'b0, ADDR_TL, 32'd0);
        step();
        chk1("t2_pwr", p_wr, 1'b1);
        chk("t2_paddr_m0", p_addr, ADDR_LED);
        chk("t2_pwdata", p_wdata, 32'h0000_003C);
        step();
        chk1("t2_m0_ack", m0_ack, 1'b1);
        chk1("t2_m1_not_yet", m1_ack, 1'b0);
        chk1("t2_prd_m1", p_rd, 1'b1);
        chk("t2_paddr_m1", p_addr, ADDR_TL);
        set_m0(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step();
        chk1("t2_m1_ack", m1_ack, 1'b1);
        chk("t2_m1_rdata", m1_rdata, 32'h0000_0010);
        chk1("t2_m1_err", m1_err, 1'b0);
        chk1("t2_m0_ack_off", m0_ack, 1'b0);
        set_m1(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step();
        chk("t2_led", pmem[3], 32'h0000_003C);
        set_m0(1'b1, 1'b1, 1'b0, 1'b0, ADDR_LED, 32'd0);
        set_m1(1'b1, 1'b1, 1'b0, 1'b0, ADDR_TL, 32'd0);
        step();
        chk("t2_tie2_m0", p_addr, ADDR_LED);
        step();
        chk1("t2_tie2_m0_ack", m0_ack, 1'b1);
        chk("t2_tie2_m0_rdata", m0_rdata, 32'h0000_003C);
        set_m0(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step();
        chk1("t2_tie2_m1_ack", m1_ack, 1'b1);
        set_m1(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step();

        // Locked read-modify-write of TCON with M1 pressing the whole time.
        set_m0(1'b1, 1'b1, 1'b0, 1'b1, ADDR_TCON, 32'd0);
        set_m1(1'b1, 1'b1, 1'b0, 1'b0, ADDR_SWITCH, 32'd0);
        step();
        chk("t3_paddr_lockrd", p_addr, ADDR_TCON);
        step();
        chk1("t3_m0_ack", m0_ack, 1'b1);
        chk("t3_m0_rdata", m0_rdata, 32'h0000_0005);
        chk1("t3_stall_a", p_rd | p_wr, 1'b0);
        set_m0(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step();
        chk1("t3_stall_b", p_rd | p_wr, 1'b0);
        step();
        chk1("t3_stall_c", p_rd | p_wr, 1'b0);
        set_m0(1'b1, 1'b0, 1'b1, 1'b0, ADDR_TCON, 32'h0000_0003);
        step();
        chk1("t3_pwr", p_wr, 1'b1);
        chk1("t3_prd_off", p_rd, 1'b0);
        chk("t3_paddr_wr", p_addr, ADDR_TCON);
        chk("t3_pwdata", p_wdata, 32'h0000_0003);
        step();
        chk1("t3_m0_wr_ack", m0_ack, 1'b1);
        chk1("t3_m1_prd", p_rd, 1'b1);
        chk("t3_m1_paddr", p_addr, ADDR_SWITCH);
        set_m0(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step();
        chk1("t3_m1_ack", m1_ack, 1'b1);
        chk("t3_m1_rdata", m1_rdata, 32'h0000_00A5);
        chk("t3_tcon", pmem[2], 32'h0000_0003);
        set_m1(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step();

        // Lock timeout: owner goes quiet for 16 LOCK_WAIT cycles.
        set_m0(1'b1, 1'b1, 1'b0, 1'b1, ADDR_TL, 32'd0);
        set_m1(1'b1, 1'b1, 1'b0, 1'b0, ADDR_DIGI, 32'd0);
        step();
        chk("t4_paddr", p_addr, ADDR_TL);
        step();
        chk1("t4_m0_ack", m0_ack, 1'b1);
        chk("t4_m0_rdata", m0_rdata, 32'h0000_0010);
        set_m0(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int k = 3; k <= 17; k++) begin
            step();
            chk1("t4_lock_err_early", lock_err, 1'b0);
            chk1("t4_m1_stalled", p_rd, 1'b0);
        end
        step();
        chk1("t4_lock_err", lock_err, 1'b1);
        chk1("t4_prd_idle", p_rd, 1'b0);
        step();
        chk1("t4_m1_prd", p_rd, 1'b1);
        chk("t4_m1_paddr", p_addr, ADDR_DIGI);
        step();
        chk1("t4_m1_ack", m1_ack, 1'b1);
        chk("t4_m1_rdata", m1_rdata, 32'h0000_0077);
        set_m1(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step();

        // Rejected commands; the locked one must not hold the bus.
        err_case("t5_range", 1'b0, 1'b1, 1'b0, 32'h4000_0018);
        err_case("t5_align", 1'b0, 1'b1, 1'b0, 32'h4000_0002);
        err_case("t5_rdwr",  1'b1, 1'b1, 1'b1, 32'h4000_0000);
        chk("t5_no_write_oob", pmem[6], 32'd0);
        chk("t5_no_write_th", pmem[0], 32'd0);
        set_m0(1'b1, 1'b1, 1'b0, 1'b0, ADDR_TH, 32'd0);
        step();
        chk1("t5_lock_ignored", p_rd, 1'b1);
        step();
        chk1("t5_m0_ack", m0_ack, 1'b1);
        set_m0(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step();
        chk1("t5_lock_err_sticky", lock_err, 1'b1);

        // Randomized traffic from both masters.
        for (int k = 0; k < 6; k++) begin
            ref_mem[k] = $urandom;
            backdoor(3'(k), ref_mem[k]);
        end
        for (int i = 0; i < 2; i++) begin
            rnd_busy[i] = 1'b0; rnd_wait[i] = 0;
            rnd_exp_err[i] = 1'b0; rnd_exp_rdata[i] = 32'd0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            step();
            chk1("rnd_strobe_onehot", p_rd & p_wr, 1'b0);
            for (int i = 0; i < 2; i++) begin
                c_ack   = (i == 0) ? m0_ack   : m1_ack;
                c_err   = (i == 0) ? m0_err   : m1_err;
                c_rdata = (i == 0) ? m0_rdata : m1_rdata;
                if (rnd_busy[i]) begin
                    if (c_ack) begin
                        chk1("rnd_err", c_err, rnd_exp_err[i]);
                        chk("rnd_rdata", c_rdata, rnd_exp_rdata[i]);
                        rnd_busy[i] = 1'b0;
                    end else begin
                        rnd_wait[i]++;
                        if (rnd_wait[i] > 8) begin
                            chk1("rnd_ack_timeout", c_ack, 1'b1);
                            rnd_busy[i] = 1'b0;
                        end
                    end
                end else begin
                    chk1("rnd_spurious_ack", c_ack, 1'b0);
                end
                if (!rnd_busy[i]) begin
                    set_m(i, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
                    if (cyc < 385 && $urandom_range(0, 2) != 0) begin
                        c_idx = pick_idx(i, int'($urandom_range(0, 2)));
                        c_addr = 32'h4000_0000 + {27'd0, c_idx, 2'b00};
                        r = int'($urandom_range(0, 11));
                        if (r == 0) c_addr = 32'h4000_0018;
                        else if (r == 1) c_addr = 32'h3FFF_FFFC;
                        else if (r == 2) c_addr = c_addr + 32'd1;
                        r = int'($urandom_range(0, 9));
                        if (r == 0)      begin c_rd = 1'b1; c_wr = 1'b1; end
                        else if (r == 1) begin c_rd = 1'b0; c_wr = 1'b0; end
                        else begin c_rd = 1'($urandom_range(0, 1)); c_wr = ~c_rd; end
                        c_wdata = $urandom;
                        rnd_exp_err[i]   = ref_err(c_addr, c_rd, c_wr);
                        rnd_exp_rdata[i] = (!rnd_exp_err[i] && c_rd) ? ref_mem[c_idx] : 32'd0;
                        if (!rnd_exp_err[i] && c_wr) ref_mem[c_idx] = c_wdata;
                        set_m(i, 1'b1, c_rd, c_wr, c_addr, c_wdata);
                        rnd_busy[i] = 1'b1;
                        rnd_wait[i] = 0;
                    end
                end
            end
        end
        chk1("rnd_drained", rnd_busy[0] | rnd_busy[1], 1'b0);
        set_m0(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_m1(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step();
        step();
        chk1("lock_err_still_set", lock_err, 1'b1);

        // Reset in the middle of an M0 write ACCESS.
        saved = pmem[3];
        set_m0(1'b1, 1'b0, 1'b1, 1'b0, ADDR_LED, saved ^ 32'h0000_0099);
        step();
        chk1("t6_pwr_before", p_wr, 1'b1);
        reset = 1'b1;
        #1;
        chk_zero("t6_async_reset");
        set_m0(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step();
        chk1("t6_no_ack", m0_ack, 1'b0);
        chk("t6_no_commit", pmem[3], saved);
        reset = 1'b0;
        step();
        chk_zero("t6_after_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/periph_bus_arbiter.md
Name: periph_bus_arbiter

Overview:
- Shares the single peripheral register bus (timer TH/TL/TCON, LED, switch, digi at 0x4000_0000–0x4000_0014) between two masters.
  - M0: CPU data port.
  - M1: DMA/UART engine.
- Issues one registered bus access per cycle and returns read data with an ack.
- Supports locked read-modify-write sequences, for example a TCON update, guarded by a lock timeout.
- Rejects accesses outside the peripheral map with an error response.

Parameters:
- LOCK_TIMEOUT, 16, LOCK_WAIT cycles allowed without an owner request before the lock is forcibly released.
- ADDR_BASE, 32'h4000_0000, first valid peripheral word address.
- ADDR_LAST, 32'h4000_0014, last valid peripheral word address.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- m0_req  in  1  M0 request; command held stable until m0_ack
- m0_rd  in  1  M0 read
- m0_wr  in  1  M0 write
- m0_lock  in  1  keep bus for M0's next transaction
- m0_addr  in  32  M0 address
- m0_wdata  in  32  M0 write data
- m0_ack  out  1  one-cycle completion pulse
- m0_err  out  1  valid with m0_ack; bad address/command
- m0_rdata  out  32  read data, valid with m0_ack, held until next ack
- m1_*  same set as m0_* for M1
- p_rd  out  1  peripheral read strobe
- p_wr  out  1  peripheral write strobe
- p_addr  out  32  peripheral address
- p_wdata  out  32  peripheral write data
- p_rdata  in  32  peripheral combinational read data
- lock_err  out  1  sticky: a lock timed out

Behaviour:
- Reset values:
  - state=IDLE, owner=M0, last_served=M1 (M0 wins the first tie), lock timer=0.
  - All outputs 0, including acks, errs, rdata, p_* and lock_err.
  - Reset mid-ACCESS drops p_rd/p_wr at once; no ack is issued and any lock is released.
- Eligibility: a master is eligible when req=1 and its ack is not high in the current cycle. Its ack-cycle command is stale and ignored.
- Winner pick (sub-module): only one eligible master wins; if both are eligible, the master != last_served wins (round-robin).
- IDLE:
  - No eligible master: stay.
  - Otherwise: register winner's command into p_* and sampled lock, set owner, go to ACCESS.
- ACCESS (exactly one cycle, bus driven):
  - Peripheral write commits at the closing edge.
  - At that edge: ownerX_rdata <= (rd ? p_rdata : 0); ownerX_ack <= 1 for one cycle; ownerX_err set accordingly; last_served <= owner.
  - If sampled lock=1: go to LOCK_WAIT and clear the timer.
  - Else: pick a winner among eligible masters excluding owner; if one exists, stay in ACCESS with the new command (back-to-back, one access/cycle); else go to IDLE.
- LOCK_WAIT:
  - Only owner is eligible; the first cycle is owner's ack cycle and is therefore ignored. The other master is stalled.
  - Owner eligible: go to ACCESS with its command.
  - Otherwise increment timer; on reaching LOCK_TIMEOUT go to IDLE and set lock_err=1. lock_err is cleared only by reset.
- Error check at grant: err if addr<ADDR_BASE, addr>ADDR_LAST, addr[1:0]!=0, rd=wr=1, or rd=wr=0.
  - On err: ACCESS still occupies one cycle, but p_rd=p_wr=0, rdata returns 0 and ack+err=1.
  - A lock on an erroneous access is ignored.
- Outside ACCESS: p_rd=p_wr=0 and p_addr=p_wdata=0.
- Latency: request sampled at edge N → ACCESS cycle N+1 → ack in cycle N+2.

Decomposition:
- Package periph_bus_pkg holds:
  - state enum {IDLE, ACCESS, LOCK_WAIT};
  - master index constants M0=0, M1=1;
  - address constants ADDR_TH/TL/TCON/LED/SWITCH/DIGI (0x…00 to 0x…14).
- Sub-module rr_arb2: 2-way combinational round-robin picker.
  - Inputs: eligible[1:0], last_served, exclude_valid, exclude_idx.
  - Outputs: grant_valid, grant_idx.

Test Plan:
- M0 reads 0x4000_0010 with switch=0xA5 → p_rd=1 for exactly one cycle; m0_ack pulses 2 cycles after request sample; m0_rdata=0x0000_00A5, m0_err=0.
- After reset, M0 writes LED 0x3C and M1 reads TL (=0x10) simultaneously → M0 is served first, M1 back-to-back in the next cycle; acks fall in consecutive cycles; m1_rdata=0x10. The next tie goes to M0.
- M0 locked read of TCON, then unlocked write TCON=3 two cycles after its ack, with M1 requesting continuously → M1 gets no p_* cycle until the cycle after M0's write ACCESS; TCON=3.
- LOCK_TIMEOUT=16: M0 locked read then req=0 → after 16 LOCK_WAIT cycles lock_err=1 and M1 is granted next; lock_err stays 1 until reset.
- M1 writes 0x4000_0018, then 0x4000_0002, then issues a command with rd=wr=1 → no p_wr/p_rd pulse; each gets m1_ack with m1_err=1 and m1_rdata=0.
- reset asserted during an ACCESS cycle of an M0 write → p_wr drops immediately, no m0_ack, state IDLE and all outputs 0.
